// File: rtl/sticker_window_sampler.sv
// sticker_window_sampler
//   Feeds the colour classifier. On a capture request it averages a
//   2**WIN_LOG2 x 2**WIN_LOG2 window centred in each cell of a 3x3 sticker
//   grid over one full frame. It then hands the nine averaged colours out
//   in row-major order over a valid/ready handshake.
//
//   Build option: define STICKER_ROUND_EN to round the averages to nearest
//   (saturating at 10'h3FF). Left undefined, the averages truncate. The
//   port list is the same in both builds.
//
// Ports
//   Clk          system clock
//   Reset_n      asynchronous reset, active low
//   Pix_valid    pixel qualifier
//   Pix_x/Pix_y  pixel column / row (10b)
//   Pix_rgb      pixel colour {R[29:20],G[19:10],B[9:0]}
//   Frame_start  first pixel of a frame (may coincide with Pix_valid)
//   Capture      one-cycle capture request (accepted only when idle)
//   Out_ready    downstream accepts Color_out
//   Color_out    averaged cell colour
//   Color_valid  Color_out / Cell_idx valid
//   Cell_idx     cell number 0..8 (row*3+col)
//   Busy         high in ARMED, ACCUM, EMIT
//   Done         one-cycle pulse after cell 8 is accepted
//   Short_frame  sticky: some cell saw a pixel count other than a full window
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for Capture
// ARMED | sums cleared, waiting for the frame to start
// ACCUM | summing window pixels until the next Frame_start
// EMIT  | handing out the nine cell averages, Cell_idx 0..8

module sticker_window_sampler #(
    parameter int X0         = 0,
    parameter int Y0         = 0,
    parameter int CELL_PITCH = 160,
    parameter int WIN_LOG2   = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Pix_valid,
    input  logic [9:0]  Pix_x,
    input  logic [9:0]  Pix_y,
    input  logic [29:0] Pix_rgb,
    input  logic        Frame_start,
    input  logic        Capture,
    input  logic        Out_ready,
    output logic [29:0] Color_out,
    output logic        Color_valid,
    output logic [3:0]  Cell_idx,
    output logic        Busy,
    output logic        Done,
    output logic        Short_frame
);

    localparam int WIN   = 2 ** WIN_LOG2;
    localparam int OFF   = (CELL_PITCH - WIN) / 2;
    localparam int SHIFT = 2 * WIN_LOG2;
    localparam int ACC_W = 10 + SHIFT;
    localparam int CNT_W = SHIFT + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = {1'b1, {SHIFT{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ACC_W:0]   HALF     = {{(ACC_W - SHIFT + 1){1'b0}}, 1'b1, {(SHIFT - 1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_ACCUM = 2'd2;
    localparam logic [1:0] S_EMIT  = 2'd3;

    logic [1:0]       state;
    logic             color_valid;
    logic [3:0]       cell_idx;
    logic             done;
    logic             short_frame;

    logic [ACC_W-1:0] acc_r [9];
    logic [ACC_W-1:0] acc_g [9];
    logic [ACC_W-1:0] acc_b [9];
    logic [CNT_W-1:0] cnt   [9];

    logic [2:0]       col_hit;
    logic [2:0]       row_hit;
    logic [8:0]       cell_hit;
    logic [31:0]      px_ext;
    logic [31:0]      py_ext;
    logic             acc_en;
    logic             start_clear;
    logic             any_short;
    logic [29:0]      avg [9];

    assign px_ext = {22'd0, Pix_x};
    assign py_ext = {22'd0, Pix_y};

    // Window bounds are elaboration-time constants. Start is inclusive, end exclusive.
    for (genvar g = 0; g < 3; g++) begin : g_bounds
        localparam logic [31:0] XLO = 32'(X0 + g * CELL_PITCH + OFF);
        localparam logic [31:0] YLO = 32'(Y0 + g * CELL_PITCH + OFF);
        assign col_hit[g] = (px_ext >= XLO) && (px_ext < XLO + 32'(WIN));
        assign row_hit[g] = (py_ext >= YLO) && (py_ext < YLO + 32'(WIN));
    end

    for (genvar r = 0; r < 3; r++) begin : g_row
        for (genvar c = 0; c < 3; c++) begin : g_col
            assign cell_hit[r*3+c] = row_hit[r] & col_hit[c];
        end
    end

    // The Frame_start pixel opens the frame in ARMED but already belongs to
    // the next frame in ACCUM.
    assign acc_en = Pix_valid &&
                    (((state == S_ACCUM) && !Frame_start) ||
                     ((state == S_ARMED) && Frame_start));

    assign start_clear = (state == S_IDLE) && Capture;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 9; i++) begin
                acc_r[i] <= '0;
                acc_g[i] <= '0;
                acc_b[i] <= '0;
                cnt[i]   <= '0;
            end
        end else if (start_clear) begin
            for (int i = 0; i < 9; i++) begin
                acc_r[i] <= '0;
                acc_g[i] <= '0;
                acc_b[i] <= '0;
                cnt[i]   <= '0;
            end
        end else if (acc_en) begin
            for (int i = 0; i < 9; i++) begin
                if (cell_hit[i]) begin
                    acc_r[i] <= acc_r[i] + ACC_W'(Pix_rgb[29:20]);
                    acc_g[i] <= acc_g[i] + ACC_W'(Pix_rgb[19:10]);
                    acc_b[i] <= acc_b[i] + ACC_W'(Pix_rgb[9:0]);
                    if (cnt[i] != CNT_MAX) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    function automatic logic [9:0] avg_ch(input logic [ACC_W-1:0] s);
`ifdef STICKER_ROUND_EN
        logic [ACC_W:0]       t;
        logic [ACC_W-SHIFT:0] q;
        t = {1'b0, s} + HALF;
        q = t[ACC_W:SHIFT];
        return q[ACC_W-SHIFT] ? 10'h3FF : q[9:0];
`else
        return s[ACC_W-1:SHIFT];
`endif
    endfunction

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            avg[i] = {avg_ch(acc_r[i]), avg_ch(acc_g[i]), avg_ch(acc_b[i])};
        end
    end

    always_comb begin
        any_short = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (cnt[i] != CNT_FULL) begin
                any_short = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_IDLE;
            color_valid <= 1'b0;
            cell_idx    <= 4'd0;
            done        <= 1'b0;
            short_frame <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Capture) begin
                        short_frame <= 1'b0;
                        state       <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (Frame_start) begin
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (Frame_start) begin
                        state <= S_EMIT;
                        if (any_short) begin
                            short_frame <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    // Color_valid is low only on the entry cycle; it then
                    // stays high until the cell-8 transfer.
                    if (!color_valid) begin
                        color_valid <= 1'b1;
                        cell_idx    <= 4'd0;
                    end else if (Out_ready) begin
                        if (cell_idx == 4'd8) begin
                            color_valid <= 1'b0;
                            cell_idx    <= 4'd0;
                            done        <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            cell_idx <= cell_idx + 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign Color_out   = color_valid ? avg[cell_idx] : 30'd0;
    assign Color_valid = color_valid;
    assign Cell_idx    = cell_idx;
    assign Busy        = (state != S_IDLE);
    assign Done        = done;
    assign Short_frame = short_frame;

endmodule

// File: tb/tb_sticker_window_sampler.sv
module tb_sticker_window_sampler;

    localparam int PITCH = 8;
    localparam int WINS  = 4;
    localparam int OFFS  = (PITCH - WINS) / 2;
    localparam int NPIX  = WINS * WINS;
    localparam int GRID  = 3 * PITCH;

    logic        Clk;
    logic        Reset_n;
    logic        Pix_valid;
    logic [9:0]  Pix_x;
    logic [9:0]  Pix_y;
    logic [29:0] Pix_rgb;
    logic        Frame_start;
    logic        Capture;
    logic        Out_ready;
    logic [29:0] Color_out;
    logic        Color_valid;
    logic [3:0]  Cell_idx;
    logic        Busy;
    logic        Done;
    logic        Short_frame;

    sticker_window_sampler #(
        .X0(0), .Y0(0), .CELL_PITCH(PITCH), .WIN_LOG2(2)
    ) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Pix_valid(Pix_valid), .Pix_x(Pix_x),
        .Pix_y(Pix_y), .Pix_rgb(Pix_rgb), .Frame_start(Frame_start),
        .Capture(Capture), .Out_ready(Out_ready), .Color_out(Color_out),
        .Color_valid(Color_valid), .Cell_idx(Cell_idx), .Busy(Busy),
        .Done(Done), .Short_frame(Short_frame)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0]  idx;
        logic [29:0] col;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   exp_short;
    bit   done_next = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: cell index from plain coordinate arithmetic, -1 outside every window.
    function automatic int cell_of(input int x, input int y);
        int cx, cy, ox, oy;
        cx = x / PITCH;  ox = x % PITCH;
        cy = y / PITCH;  oy = y % PITCH;
        if (cx > 2 || cy > 2) return -1;
        if (ox < OFFS || ox >= OFFS + WINS) return -1;
        if (oy < OFFS || oy >= OFFS + WINS) return -1;
        return cy * 3 + cx;
    endfunction

    function automatic logic [9:0] mean_of(input int s);
        int v;
`ifdef STICKER_ROUND_EN
        v = (s + NPIX / 2) / NPIX;
        if (v > 1023) v = 1023;
`else
        v = s / NPIX;
`endif
        return 10'(v);
    endfunction

    // Monitor / scoreboard: peek while valid (stability under stall), pop on transfer.
    always @(negedge Clk) begin
        if (!Reset_n) begin
            done_next = 1'b0;
        end else begin
            chk("done_pulse", {31'd0, Done}, {31'd0, done_next});
            done_next = 1'b0;
            if (Color_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got idx %0d color %0h expected none", Cell_idx, Color_out);
                end else begin
                    chk("cell_idx", {28'd0, Cell_idx}, {28'd0, exp_q[0].idx});
                    chk("color_out", {2'd0, Color_out}, {2'd0, exp_q[0].col});
                    if (Out_ready) begin
                        if (exp_q[0].idx == 4'd8) done_next = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        Pix_valid   = 1'b0;
        Frame_start = 1'b0;
        Capture     = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_color_valid"}, {31'd0, Color_valid}, 32'd0);
        chk({tag, "_color_out"}, {2'd0, Color_out}, 32'd0);
        chk({tag, "_cell_idx"}, {28'd0, Cell_idx}, 32'd0);
        chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, Done}, 32'd0);
        chk({tag, "_short"}, {31'd0, Short_frame}, 32'd0);
    endtask

    task automatic do_capture();
        idle_inputs();
        Capture = 1'b1;
        tick();
        Capture = 1'b0;
        chk("busy_after_capture", {31'd0, Busy}, 32'd1);
        chk("short_cleared_by_capture", {31'd0, Short_frame}, 32'd0);
        // Window pixels while ARMED without Frame_start must be ignored.
        for (int k = 0; k < 3; k++) begin
            Pix_valid = 1'b1;
            Pix_x = 10'(OFFS + k);
            Pix_y = 10'(OFFS);
            Pix_rgb = 30'($urandom);
            tick();
        end
        idle_inputs();
    endtask

    // mode 0: constant red, 1: random (gaps, off-grid pixels), 2: cell-4 R 100/101 split
    task automatic send_frame(input int mode, input bit skip_one, input int cap_at, input int rst_at);
        int sr[9], sg[9], sb[9], cn[9];
        int n4, L, x, y, c;
        logic [29:0] rgb;
        logic [9:0]  r10;
        for (int i = 0; i < 9; i++) begin
            sr[i] = 0; sg[i] = 0; sb[i] = 0; cn[i] = 0;
        end
        n4 = 0;
        for (int p = 0; p < GRID * GRID; p++) begin
            L = (p + OFFS * GRID + OFFS) % (GRID * GRID);
            x = L % GRID;
            y = L / GRID;
            if (mode == 1 && p != 0 && $urandom_range(3) == 0) begin
                Pix_valid = 1'b0; Frame_start = 1'b0; Capture = 1'b0;
                Pix_x = 10'($urandom); Pix_y = 10'($urandom); Pix_rgb = 30'($urandom);
                tick();
            end
            if (mode == 1 && p != 0 && $urandom_range(7) == 0) begin
                Pix_valid = 1'b1; Frame_start = 1'b0; Capture = 1'b0;
                Pix_x = 10'($urandom_range(1023, GRID)); Pix_y = 10'($urandom_range(1023));
                Pix_rgb = 30'($urandom);
                tick();
            end
            c = cell_of(x, y);
            case (mode)
                0: rgb = 30'h3FF00000;
                2: begin
                    rgb = 30'($urandom);
                    if (c == 4) begin
                        r10 = (n4 < 8) ? 10'd100 : 10'd101;
                        rgb = {r10, rgb[19:0]};
                        n4++;
                    end
                end
                default: rgb = 30'($urandom);
            endcase
            if (p == rst_at) begin
                Reset_n = 1'b0;
                #1;
                check_all_zero("reset_mid_accum");
                idle_inputs();
                tick();
                tick();
                Reset_n = 1'b1;
                return;
            end
            Pix_valid   = !(skip_one && x == OFFS + 1 && y == OFFS + 1);
            Frame_start = (p == 0);
            Capture     = (p == cap_at);
            Pix_x = 10'(x); Pix_y = 10'(y); Pix_rgb = rgb;
            if (Pix_valid && c >= 0) begin
                sr[c] += int'(rgb[29:20]);
                sg[c] += int'(rgb[19:10]);
                sb[c] += int'(rgb[9:0]);
                cn[c]++;
            end
            tick();
        end
        exp_short = 1'b0;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back('{idx: 4'(i), col: {mean_of(sr[i]), mean_of(sg[i]), mean_of(sb[i])}});
            if (cn[i] != NPIX) exp_short = 1'b1;
        end
        // Closing Frame_start carries an in-window pixel that must not be summed.
        Pix_valid = 1'b1; Frame_start = 1'b1; Capture = 1'b0;
        Pix_x = 10'(OFFS); Pix_y = 10'(OFFS); Pix_rgb = 30'($urandom);
        tick();
        idle_inputs();
    endtask

    // rmode 0: always ready, 1: random ready, 2: ready low 5 cycles at Cell_idx 3
    task automatic wait_done(input int rmode, input bit cap_in_emit);
        bit got, stalled;
        int stall_left;
        got = 1'b0; stalled = 1'b0; stall_left = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            case (rmode)
                0: Out_ready = 1'b1;
                1: Out_ready = 1'($urandom_range(1));
                default: begin
                    if (stall_left > 0) begin
                        Out_ready = 1'b0;
                        stall_left--;
                    end else if (!stalled && Color_valid && Cell_idx == 4'd3) begin
                        stalled = 1'b1;
                        stall_left = 4;
                        Out_ready = 1'b0;
                    end else begin
                        Out_ready = 1'b1;
                    end
                end
            endcase
            Pix_valid   = 1'($urandom_range(1));
            Pix_x       = 10'($urandom_range(GRID - 1));
            Pix_y       = 10'($urandom_range(GRID - 1));
            Pix_rgb     = 30'($urandom);
            Frame_start = ($urandom_range(15) == 0);
            Capture     = cap_in_emit && ($urandom_range(3) == 0);
            tick();
            if (Done) got = 1'b1;
        end
        idle_inputs();
        Out_ready = 1'b1;
        chk("done_within_budget", {31'd0, got}, 32'd1);
        if (rmode == 2) chk("stall_at_idx3_seen", {31'd0, stalled}, 32'd1);
        chk("busy_after_done", {31'd0, Busy}, 32'd0);
        chk("all_cells_emitted", 32'(exp_q.size()), 32'd0);
        chk("short_frame", {31'd0, Short_frame}, {31'd0, exp_short});
    endtask

    initial begin
        Reset_n = 1'b0;
        Out_ready = 1'b0;
        Pix_x = '0; Pix_y = '0; Pix_rgb = '0;
        idle_inputs();
        repeat (3) @(posedge Clk);
        #1;
        check_all_zero("reset");
        Reset_n = 1'b1;
        tick();

        // constant frame, always ready
        do_capture(); send_frame(0, 1'b0, -1, -1); wait_done(0, 1'b0);
        // cell-4 100/101 split, random ready
        do_capture(); send_frame(2, 1'b0, -1, -1); wait_done(1, 1'b0);
        // random frame, stall at cell 3
        do_capture(); send_frame(1, 1'b0, -1, -1); wait_done(2, 1'b0);
        // cell 0 misses one pixel
        do_capture(); send_frame(0, 1'b1, -1, -1); wait_done(0, 1'b0);
        // Capture pulses inside ACCUM and EMIT are ignored
        do_capture(); send_frame(1, 1'b0, 200, -1); wait_done(1, 1'b1);
        for (int k = 0; k < 40; k++) begin
            Capture = 1'b0;
            Pix_valid = 1'($urandom_range(1));
            Frame_start = ($urandom_range(7) == 0);
            tick();
        end
        idle_inputs();
        chk("idle_after_ignored_captures", {31'd0, Busy}, 32'd0);
        // reset mid-ACCUM, then a clean capture
        do_capture(); send_frame(1, 1'b0, -1, 300);
        tick();
        check_all_zero("after_reset_release");
        do_capture(); send_frame(1, 1'b0, -1, -1); wait_done(1, 1'b0);
        // short random frame, then reset while idle clears the sticky flag
        do_capture(); send_frame(1, 1'b1, -1, -1); wait_done(1, 1'b0);
        Reset_n = 1'b0;
        #1;
        chk("reset_clears_short", {31'd0, Short_frame}, 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        do_capture(); send_frame(2, 1'b0, -1, -1); wait_done(2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
